// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory access arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DBG} owner_e;

  localparam int unsigned MEM_BYTES_DEF  = 64;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Word access must be aligned and fit entirely inside the memory.
  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input int unsigned mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of fetch grants made while debug waits; forces a debug win at the limit.
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_grant,
  input  logic dbg_grant,
  input  logic dbg_pending,
  output logic force_dbg
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dbg_grant) begin
      cnt_d = '0;
    end else if (fetch_grant) begin
      if (!dbg_pending)          cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_dbg = (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the instruction-memory read port between fetch and debug: IDLE -> ACCESS -> RESP,
// fetch priority with a starvation guard, and range/alignment checking of every address.
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic        IfValid,
  output logic [31:0] IfData,
  output logic        IfError,
  input  logic        DbgReq,
  input  logic [31:0] DbgAddr,
  output logic        DbgValid,
  output logic [31:0] DbgData,
  output logic        DbgError,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemData,
  input  logic        MemError
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        bad_q, bad_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        if_valid_q, if_valid_d, dbg_valid_q, dbg_valid_d;
  logic [31:0] if_data_q, if_data_d, dbg_data_q, dbg_data_d;
  logic        if_err_q, if_err_d, dbg_err_q, dbg_err_d;

  logic        force_dbg, fetch_grant, dbg_grant, pick_dbg, req_bad;
  logic [31:0] req_addr, rd_data;
  logic        rd_err;

  assign pick_dbg = DbgReq && (!IfReq || force_dbg);
  assign req_addr = pick_dbg ? DbgAddr : IfAddr;
  assign req_bad  = addr_illegal(req_addr, MEM_BYTES);
  // A rejected address never reaches memory, so its response is synthesised here.
  assign rd_data  = bad_q ? 32'd0 : MemData;
  assign rd_err   = bad_q | MemError;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bad_d       = bad_q;
    mem_addr_d  = mem_addr_q;
    if_valid_d  = 1'b0;
    dbg_valid_d = 1'b0;
    if_data_d   = if_data_q;
    if_err_d    = if_err_q;
    dbg_data_d  = dbg_data_q;
    dbg_err_d   = dbg_err_q;
    fetch_grant = 1'b0;
    dbg_grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (IfReq || DbgReq) begin
          fetch_grant = !pick_dbg;
          dbg_grant   = pick_dbg;
          owner_d     = pick_dbg ? OWN_DBG : OWN_IF;
          bad_d       = req_bad;
          if (!req_bad) mem_addr_d = req_addr;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (owner_q == OWN_DBG) begin
          dbg_valid_d = 1'b1;
          dbg_data_d  = rd_data;
          dbg_err_d   = rd_err;
        end else begin
          if_valid_d = 1'b1;
          if_data_d  = rd_data;
          if_err_d   = rd_err;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      bad_q       <= 1'b0;
      mem_addr_q  <= '0;
      if_valid_q  <= 1'b0;
      dbg_valid_q <= 1'b0;
      if_data_q   <= '0;
      if_err_q    <= 1'b0;
      dbg_data_q  <= '0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bad_q       <= bad_d;
      mem_addr_q  <= mem_addr_d;
      if_valid_q  <= if_valid_d;
      dbg_valid_q <= dbg_valid_d;
      if_data_q   <= if_data_d;
      if_err_q    <= if_err_d;
      dbg_data_q  <= dbg_data_d;
      dbg_err_q   <= dbg_err_d;
    end
  end

  imem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (Clk),
    .rst_n      (Rst),
    .fetch_grant(fetch_grant),
    .dbg_grant  (dbg_grant),
    .dbg_pending(DbgReq),
    .force_dbg  (force_dbg)
  );

  assign IfValid  = if_valid_q;
  assign IfData   = if_data_q;
  assign IfError  = if_err_q;
  assign DbgValid = dbg_valid_q;
  assign DbgData  = dbg_data_q;
  assign DbgError = dbg_err_q;
  assign MemAddr  = mem_addr_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomised and directed bench for imem_access_arbiter against a transaction-level model.
module tb_imem_access_arbiter;

  localparam int MEM_BYTES  = 64;
  localparam int STARVE_MAX = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IfReq, DbgReq;
  logic [31:0] IfAddr, DbgAddr;
  logic        IfValid, IfError, DbgValid, DbgError, MemError;
  logic [31:0] IfData, DbgData, MemAddr, MemData;

  logic [31:0] mem  [16];
  logic        merr [16];

  assign MemData  = mem[MemAddr[5:2]];
  assign MemError = merr[MemAddr[5:2]];

  always #5 Clk = ~Clk;

  imem_access_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfValid(IfValid), .IfData(IfData), .IfError(IfError),
    .DbgReq(DbgReq), .DbgAddr(DbgAddr), .DbgValid(DbgValid), .DbgData(DbgData),
    .DbgError(DbgError),
    .MemAddr(MemAddr), .MemData(MemData), .MemError(MemError)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: a grant occupies the port for 3 cycles, answers 2 cycles later.
  int          cyc = 0;
  int          free_c = 0;
  int          starve = 0;
  bit          resp_pend = 0;
  int          resp_c;
  int          resp_own;
  logic [31:0] resp_addr;
  bit          resp_bad;
  logic [31:0] exp_memaddr = '0;
  logic [31:0] exp_data [2] = '{32'd0, 32'd0};
  logic        exp_err  [2] = '{1'b0, 1'b0};
  bit          vseen    [2] = '{1'b0, 1'b0};

  task automatic model_arbitrate();
    bit dw, bad;
    logic [31:0] a;
    if (!Rst) begin
      resp_pend   = 0;
      free_c      = cyc + 1;
      starve      = 0;
      exp_memaddr = '0;
      exp_data    = '{32'd0, 32'd0};
      exp_err     = '{1'b0, 1'b0};
    end else if (cyc >= free_c && (IfReq || DbgReq)) begin
      dw = DbgReq && (!IfReq || starve == STARVE_MAX);
      if (dw)          starve = 0;
      else if (DbgReq) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      else             starve = 0;
      a   = dw ? DbgAddr : IfAddr;
      bad = (a % 4 != 0) || (a > MEM_BYTES - 4);
      if (!bad) exp_memaddr = a;
      resp_pend = 1;
      resp_c    = cyc + 2;
      resp_own  = dw ? 1 : 0;
      resp_addr = a;
      resp_bad  = bad;
      free_c    = cyc + 3;
    end
  endtask

  task automatic check_outputs();
    bit ev [2];
    ev = '{1'b0, 1'b0};
    if (resp_pend && resp_c == cyc) begin
      ev[resp_own]       = 1'b1;
      exp_data[resp_own] = resp_bad ? 32'd0 : mem[resp_addr[5:2]];
      exp_err[resp_own]  = resp_bad ? 1'b1 : merr[resp_addr[5:2]];
      resp_pend = 0;
    end
    chk("IfValid",  IfValid,  ev[0]);
    chk("IfData",   IfData,   exp_data[0]);
    chk("IfError",  IfError,  exp_err[0]);
    chk("DbgValid", DbgValid, ev[1]);
    chk("DbgData",  DbgData,  exp_data[1]);
    chk("DbgError", DbgError, exp_err[1]);
    chk("MemAddr",  MemAddr,  exp_memaddr);
    vseen = ev;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      model_arbitrate();
      @(posedge Clk);
      #1;
      cyc++;
      check_outputs();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      1:       return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'd64 + (32'($urandom_range(0, 63)) << 2);
      default: return 32'($urandom_range(0, 15)) << 2;
    endcase
  endfunction

  int n_if_before_dbg;
  bit dbg_done;
  bit          rq [2];
  logic [31:0] ad [2];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = $urandom;
      merr[i] = 1'b0;
    end
    Rst = 1'b0; IfReq = 1'b0; DbgReq = 1'b0; IfAddr = '0; DbgAddr = '0;

    // Reset, then first fetch at 0x00
    run(2);
    Rst = 1'b1;
    IfReq = 1'b1; IfAddr = 32'h00;
    run(2);
    chk("first_if_valid", IfValid, 1);
    chk("first_if_data",  IfData,  mem[0]);
    IfReq = 1'b0;
    run(1);

    // Collision: fetch first, debug three cycles later
    IfReq = 1'b1; IfAddr = 32'h04; DbgReq = 1'b1; DbgAddr = 32'h08;
    run(2);
    chk("coll_if_valid", IfValid, 1);
    chk("coll_if_data",  IfData,  mem[1]);
    IfReq = 1'b0;
    run(3);
    chk("coll_dbg_valid", DbgValid, 1);
    chk("coll_dbg_data",  DbgData,  mem[2]);
    DbgReq = 1'b0;
    run(1);

    // Starvation guard
    IfReq = 1'b1; IfAddr = 32'h0C; DbgReq = 1'b1; DbgAddr = 32'h20;
    n_if_before_dbg = 0; dbg_done = 0;
    for (int i = 0; i < 18; i++) begin
      run(1);
      if (IfValid && !dbg_done) n_if_before_dbg++;
      if (DbgValid) begin dbg_done = 1; DbgReq = 1'b0; end
      if (vseen[0]) IfAddr = 32'($urandom_range(0, 15)) << 2;
    end
    chk("starve_fetches", 32'(n_if_before_dbg), 32'(STARVE_MAX));
    chk("starve_dbg_served", 32'(dbg_done), 1);
    IfReq = 1'b0; DbgReq = 1'b0;
    run(3);

    // Bad addresses: misaligned, then past the end
    IfReq = 1'b1; IfAddr = 32'h02;
    run(2);
    chk("misalign_err",  IfError, 1);
    chk("misalign_data", IfData,  0);
    IfAddr = 32'h3D;
    run(3);
    chk("range_valid", IfValid, 1);
    chk("range_err",   IfError, 1);
    IfReq = 1'b0;
    run(1);

    // Memory miss reported through debug
    merr[4] = 1'b1;
    DbgReq = 1'b1; DbgAddr = 32'h10;
    run(2);
    chk("miss_dbg_err",  DbgError, 1);
    chk("miss_dbg_data", DbgData,  mem[4]);
    DbgReq = 1'b0;
    run(1);
    merr[4] = 1'b0;

    // Reset during ACCESS discards the access
    IfReq = 1'b1; IfAddr = 32'h0C;
    run(1);
    Rst = 1'b0;
    run(1);
    chk("rst_mid_no_valid", IfValid, 0);
    Rst = 1'b1;
    run(2);
    chk("rst_mid_after_valid", IfValid, 1);
    chk("rst_mid_after_data",  IfData,  mem[3]);
    IfReq = 1'b0;
    run(1);

    // Random traffic with occasional resets and memory misses
    for (int i = 0; i < 16; i++) merr[i] = ($urandom_range(0, 7) == 0);
    rq = '{1'b0, 1'b0};
    ad = '{32'd0, 32'd0};
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (vseen[r]) begin
          rq[r] = ($urandom_range(0, 1) != 0);
          if (rq[r]) ad[r] = rand_addr();
        end else if (!rq[r] && $urandom_range(0, 3) == 0) begin
          rq[r] = 1'b1;
          ad[r] = rand_addr();
        end
      end
      IfReq = rq[0]; IfAddr = ad[0]; DbgReq = rq[1]; DbgAddr = ad[1];
      Rst = ($urandom_range(0, 79) != 0);
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
# imem_access_arbiter

Shares the single read port of the byte-addressed 64-byte instruction memory between two requesters: the IF-stage fetch unit and the debug/program-inspection port. It sits between both requesters and the instruction memory's address/data/error pins. It sequences each access through a small FSM, applies fixed fetch priority with a starvation guard for debug, and range/alignment-checks every address. It returns registered data, valid and error per requester.

## Interface
Parameters:
- MEM_BYTES, 64, memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- STARVE_MAX, 4, consecutive fetch grants allowed while debug waits before debug is forced.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-low.
- IfReq  in  1  fetch request, level; held until IfValid.
- IfAddr  in  32  fetch byte address; stable while IfReq high.
- IfValid  out  1  one-cycle response pulse to fetch.
- IfData  out  32  fetch word, little-endian as assembled by memory.
- IfError  out  1  fetch error, qualified by IfValid.
- DbgReq  in  1  debug request, same rules as IfReq.
- DbgAddr  in  32  debug byte address.
- DbgValid  out  1  one-cycle response pulse to debug.
- DbgData  out  32  debug word.
- DbgError  out  1  debug error, qualified by DbgValid.
- MemAddr  out  32  registered address to instruction memory.
- MemData  in  32  combinational read data from memory.
- MemError  in  1  memory miss flag, sampled with MemData.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Any request: grant one requester, latch owner and address check, go to ACCESS.
  - Legal address: MemAddr <= granted address.
  - Illegal address: MemAddr holds its value and the memory is not accessed.
- ACCESS:
  - Capture owner's Data <= MemData and Error <= MemError.
  - Illegal address: capture Data <= 0 and Error <= 1 instead.
  - Assert owner's Valid. Go to RESP.
- RESP:
  - Owner's Valid high for exactly this cycle. All requests are ignored.
  - Go to IDLE.
  - The requester must drop Req, or present a new address, by the next cycle.
- Illegal address: Addr[1:0] != 0, or Addr > MEM_BYTES-4.
- Arbitration, evaluated only in IDLE:
  - Fetch wins when both request, unless the starvation count equals STARVE_MAX; then debug wins.
  - Starvation counter (width clog2(STARVE_MAX+1)):
    - Increments on each fetch grant made while DbgReq is high.
    - Clears on a debug grant, or on a fetch grant made with DbgReq low.
    - Never exceeds STARVE_MAX.
- Non-owner Valid stays 0. Non-owner Data and Error hold their last values.
- Reset (Rst low at an edge, in any state):
  - State <= IDLE, MemAddr <= 0, counter <= 0, owner cleared.
  - All Valid/Data/Error outputs <= 0.
  - An in-flight access is discarded with no Valid pulse.

## Timing
- Req high in cycle 0 with grant in IDLE: MemAddr valid in cycle 1, Valid high in cycle 2.
- Request latency is 2 cycles. Peak throughput is one access per 3 cycles.
- A losing requester keeps Req high and is served by the next IDLE evaluation, 3 cycles later at minimum.
- Error responses have identical timing to good responses.
- Rst is sampled only at the rising edge; no asynchronous path.
- MemError is sampled only in ACCESS.

## Structure
- Package imem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - owner encoding {OWN_IF, OWN_DBG};
  - default MEM_BYTES and STARVE_MAX constants.
- One sub-module, imem_arb_starve_ctr: the saturating starvation counter.
  - Inputs: fetch_grant, dbg_grant, dbg_pending.
  - Output: force_dbg (count == STARVE_MAX).
- Top module holds the FSM, address checker, response registers and MemAddr register.

## Test plan
- Reset: hold Rst=0 for 2 cycles, release -> all outputs 0, state IDLE; first IfReq at 0x00 -> IfValid in cycle 2, IfData = memory word at 0.
- Collision: IfReq at 0x04 and DbgReq at 0x08 in the same cycle -> IfValid in cycle 2; DbgValid in cycle 5 with word at 0x08.
- Starvation: continuous IfReq with DbgReq held high -> four fetch responses, then a DbgValid, then fetch resumes; counter returns to 0.
- Bad address:
  - IfAddr=0x02 -> IfValid with IfError=1 and IfData=0 at the normal latency; MemAddr unchanged.
  - IfAddr=0x3D (> MEM_BYTES-4) -> same.
- Memory miss: MemError=1 during ACCESS for DbgAddr 0x10 -> DbgValid with DbgError=1, DbgData = MemData.
- Reset mid-access: Rst=0 in the ACCESS cycle -> no Valid pulse follows; next request after release completes normally with latency 2.
